// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
// Contents: NREQ, requester ID enum, arbiter state enum, read-pipe entry struct,
//           one-hot <-> ID conversion helpers.
package mem_arb_pkg;

   localparam int NREQ = 3;

   typedef enum logic [1:0] {
      REQ_IFETCH = 2'd0,
      REQ_DATA   = 2'd1,
      REQ_VPU    = 2'd2
   } req_id_e;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic    valid;
      req_id_e id;
   } rd_entry_t;

   function automatic req_id_e onehot_to_id(input logic [NREQ-1:0] oh);
      req_id_e id;
      id = REQ_IFETCH;
      if (oh[1]) id = REQ_DATA;
      if (oh[2]) id = REQ_VPU;
      return id;
   endfunction

   function automatic logic [NREQ-1:0] id_to_onehot(input req_id_e id);
      logic [NREQ-1:0] oh;
      oh = 3'b001 << id;
      return oh;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational one-hot winner search starting at a given index
// Ports:
//   req_i   : request vector (bit i = requester i)
//   start_i : index searched first, wrapping modulo NREQ
//   win_o   : one-hot winner, zero when no request
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic [NREQ-1:0] req_i,
   input  logic [1:0]      start_i,
   output logic [NREQ-1:0] win_o
);

   logic [2:0] idx;
   logic       found;

   always_comb begin
      win_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, start_i} + 3'(k);
         if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
         if (!found && req_i[idx[1:0]]) begin
            win_o[idx[1:0]] = 1'b1;
            found           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-way arbiter for the shared memory port with read-response routing
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (defined: round-robin, undefined: fixed 0>1>2).
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   req_i/we_i/lock_i    : per-requester request, write enable, keep-ownership
//   addr_i/wdata_i       : packed per-requester payload
//   gnt_o                : one-hot combinational grant
//   rvalid_o/rdata_o     : one-hot read response strobe and data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o : registered memory command
//   mem_rdata_i          : memory read data, MEM_LAT cycles after a read command
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ-1:0]          we_i,
   input  logic [NREQ-1:0]          lock_i,
   input  logic [NREQ*ADDR_W-1:0]   addr_i,
   input  logic [NREQ*DATA_W-1:0]   wdata_i,
   output logic [NREQ-1:0]          gnt_o,
   output logic [NREQ-1:0]          rvalid_o,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     mem_en_o,
   output logic                     mem_we_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic [DATA_W-1:0]        mem_wdata_o,
   input  logic [DATA_W-1:0]        mem_rdata_i
);

   arb_state_e      state_q, state_d;
   req_id_e         owner_q, owner_d;
   logic [NREQ-1:0] elig, win;
   logic [1:0]      start;
   req_id_e         win_id;
   logic            any_win;

   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   req_id_e           id_q;
   rd_entry_t         pipe_q [MEM_LAT];

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Last granted requester; reset to VPU so the first search starts at IFETCH.
   req_id_e ptr_q;

   assign start = (ptr_q == REQ_VPU) ? 2'd0 : ptr_q + 2'd1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        ptr_q <= REQ_VPU;
      else if (any_win) ptr_q <= win_id;
   end
`else
   assign start = 2'd0;
`endif

   // While locked only the owner competes; everyone else simply waits.
   assign elig = (state_q == ARB_LOCKED) ? (req_i & id_to_onehot(owner_q)) : req_i;

   arb_pick u_pick (
      .req_i   (elig),
      .start_i (start),
      .win_o   (win)
   );

   assign win_id  = onehot_to_id(win);
   assign any_win = |win;
   assign gnt_o   = rst_i ? '0 : win;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ARB_IDLE: begin
            if (any_win && lock_i[win_id]) begin
               state_d = ARB_LOCKED;
               owner_d = win_id;
            end
         end
         ARB_LOCKED: begin
            if (any_win && !lock_i[owner_q]) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ARB_IDLE;
         owner_q     <= REQ_IFETCH;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         id_q        <= REQ_IFETCH;
         for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         mem_en_q <= any_win;
         if (any_win) begin
            mem_we_q    <= we_i[win_id];
            mem_addr_q  <= addr_i[win_id*ADDR_W +: ADDR_W];
            mem_wdata_q <= wdata_i[win_id*DATA_W +: DATA_W];
            id_q        <= win_id;
         end
         // Entry enters alongside the memory command, so the last stage lines up
         // with mem_rdata exactly MEM_LAT cycles later.
         pipe_q[0] <= '{valid: mem_en_q & ~mem_we_q, id: id_q};
         for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rvalid_o    = pipe_q[MEM_LAT-1].valid ? id_to_onehot(pipe_q[MEM_LAT-1].id) : '0;
   assign rdata_o     = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    req = '0, we = '0, lock = '0;
   logic [3*AW-1:0] addr  = '0;
   logic [3*DW-1:0] wdata = '0;
   logic [2:0]    gnt, rvalid;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   typedef struct { int due; logic we; logic [AW-1:0] a; logic [DW-1:0] d; } iss_t;
   typedef struct { int due; logic [2:0] rv; logic [DW-1:0] d; } rsp_t;
   iss_t iss_q[$];
   rsp_t rsp_q[$];

   logic          mp_v [LAT];
   logic [AW-1:0] mp_a [LAT];

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .we_i        (we),
      .lock_i      (lock),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .gnt_o       (gnt),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      return {a ^ 16'hC3C3, ~a};
   endfunction

   // Memory model: read data appears LAT cycles after a read command.
   always @(posedge clk) begin
      mp_v[0] <= mem_en & ~mem_we;
      mp_a[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) begin
         mp_v[i] <= mp_v[i-1];
         mp_a[i] <= mp_a[i-1];
      end
   end
   assign mem_rdata = (mp_v[LAT-1] === 1'b1) ? mem_fn(mp_a[LAT-1]) : 32'hDEAD_BEEF;

   function automatic int oh2i(input logic [2:0] oh);
      return oh[2] ? 2 : (oh[1] ? 1 : 0);
   endfunction

   // Record expected memory command and (for reads) response for a grant to id this cycle.
   task automatic sb_push(input int id);
      iss_t e;
      rsp_t r;
      e.due = cyc + 1;
      e.we  = we[id];
      e.a   = addr[id*AW +: AW];
      e.d   = wdata[id*DW +: DW];
      iss_q.push_back(e);
      if (!we[id]) begin
         r.due = cyc + 1 + LAT;
         r.rv  = 3'b001 << id;
         r.d   = mem_fn(e.a);
         rsp_q.push_back(r);
      end
   endtask

   // Scoreboard pop side: every cycle, memory command and read response are compared.
   always @(negedge clk) begin
      if (mon_en) begin
         #2;
         n_cmp++;
         if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, iss_q[0].we, iss_q[0].a, iss_q[0].d}) begin
               n_bad++;
               $display("FAIL issue cyc%0d: got en=%b we=%b a=%h d=%h, want en=1 we=%b a=%h d=%h",
                        cyc, mem_en, mem_we, mem_addr, mem_wdata, iss_q[0].we, iss_q[0].a, iss_q[0].d);
            end
            void'(iss_q.pop_front());
         end else if (mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_en cyc%0d: got mem_en=%b, want 0", cyc, mem_en);
         end
         n_cmp++;
         if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            if (rvalid !== rsp_q[0].rv || rdata !== rsp_q[0].d) begin
               n_bad++;
               $display("FAIL response cyc%0d: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                        cyc, rvalid, rdata, rsp_q[0].rv, rsp_q[0].d);
            end
            void'(rsp_q.pop_front());
         end else if (rvalid !== 3'b000) begin
            n_bad++;
            $display("FAIL spurious_rvalid cyc%0d: got rvalid=%b, want 000", cyc, rvalid);
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; we = '0; lock = '0;
      iss_q.delete();
      rsp_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      @(negedge clk);
      req = '0; lock = '0;
      repeat (LAT + 3) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      req = 3'b111; we = 3'b111; addr = {16'h3333, 16'h2222, 16'h1111}; wdata = {3{32'hFFFF_FFFF}};
      #1;
      n_cmp++; if (gnt !== 3'b000)      begin n_bad++; $display("FAIL reset_gnt: got %b want 000", gnt); end
      n_cmp++; if (mem_en !== 1'b0)     begin n_bad++; $display("FAIL reset_en: got %b want 0", mem_en); end
      n_cmp++; if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
      n_cmp++; if (mem_addr !== '0)     begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      n_cmp++; if (mem_wdata !== '0)    begin n_bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
      n_cmp++; if (rvalid !== 3'b000)   begin n_bad++; $display("FAIL reset_rvalid: got %b want 000", rvalid); end
      @(negedge clk);
      req = '0; we = '0; rst = 1'b0;
   endtask

   task automatic test_first_after_reset();
      apply_reset();
      @(negedge clk);
      req = 3'b111; we = 3'b000; addr = {16'h0300, 16'h0200, 16'h0100};
      #1;
      n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL first_grant: got %b want 001", gnt); end
      sb_push(0);
      drain();
   endtask

   task automatic test_single_read();
      logic [2:0] t_req [5] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
      apply_reset();
      addr = {16'h0000, 16'h0000, 16'h0010}; wdata = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req = t_req[k]; we = '0; lock = '0;
         #1;
         n_cmp++;
         if (gnt !== t_req[k]) begin n_bad++; $display("FAIL single_read_gnt k%0d: got %b want %b", k, gnt, t_req[k]); end
         if (t_req[k] != 3'b000) sb_push(0);
      end
      drain();
   endtask

   task automatic test_arbitration();
      logic [2:0] exp;
      apply_reset();
      addr  = {16'h0300, 16'h0200, 16'h0100};
      wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         req = 3'b111; we = 3'b010; lock = '0;
         #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp = 3'b001 << (k % 3);
`else
         exp = 3'b001;
`endif
         n_cmp++;
         if (gnt !== exp) begin n_bad++; $display("FAIL arb_order k%0d: got %b want %b", k, gnt, exp); end
         sb_push(oh2i(exp));
      end
      drain();
   endtask

   task automatic test_lock();
      logic [2:0] t_req  [6] = '{3'b100, 3'b010, 3'b110, 3'b110, 3'b110, 3'b010};
      logic [2:0] t_lock [6] = '{3'b100, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
      logic [2:0] t_gnt  [6] = '{3'b100, 3'b000, 3'b100, 3'b100, 3'b100, 3'b010};
      apply_reset();
      addr = {16'h0400, 16'h0500, 16'h0000};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         req = t_req[k]; lock = t_lock[k]; we = 3'b100;
         wdata = {32'hB000_0000 + 32'(k), 32'h0, 32'h0};
         #1;
         n_cmp++;
         if (gnt !== t_gnt[k]) begin n_bad++; $display("FAIL lock_gnt k%0d: got %b want %b", k, gnt, t_gnt[k]); end
         if (t_gnt[k] != 3'b000) sb_push(oh2i(t_gnt[k]));
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [2:0] t_req [3] = '{3'b001, 3'b010, 3'b100};
      apply_reset();
      addr  = {16'h0040, 16'h0030, 16'h0020};
      wdata = {32'h0, 32'h1234_5678, 32'h0};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req = t_req[k]; we = 3'b010; lock = '0;
         #1;
         n_cmp++;
         if (gnt !== t_req[k]) begin n_bad++; $display("FAIL b2b_gnt k%0d: got %b want %b", k, gnt, t_req[k]); end
         sb_push(k);
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      apply_reset();
      addr = {16'h0060, 16'h0000, 16'h0050}; wdata = '0;
      @(negedge clk);
      req = 3'b001; we = '0; #1;
      n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL mid_gnt0: got %b want 001", gnt); end
      sb_push(0);
      @(negedge clk);
      req = 3'b100; #1;
      n_cmp++; if (gnt !== 3'b100) begin n_bad++; $display("FAIL mid_gnt1: got %b want 100", gnt); end
      sb_push(2);
      @(negedge clk);
      req = 3'b000;
      // Both reads are now in flight; their responses must never appear.
      @(negedge clk);
      rst = 1'b1; req = 3'b111;
      rsp_q.delete();
      iss_q.delete();
      #1;
      n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL mid_rst_gnt: got %b want 000", gnt); end
      @(negedge clk);
      rst = 1'b0; req = 3'b000;
      for (int k = 0; k < LAT + 3; k++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({rvalid, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_bad++;
            $display("FAIL mid_after k%0d: got rvalid=%b en=%b we=%b a=%h d=%h, want all 0",
                     k, rvalid, mem_en, mem_we, mem_addr, mem_wdata);
         end
      end
   endtask

   initial begin
      test_reset();
      mon_en = 1'b1;
      test_first_after_reset();
      test_single_read();
      test_arbitration();
      test_lock();
      test_back_to_back();
      test_reset_midflight();
      @(negedge clk);
      mon_en = 1'b0;
      #3;
      n_cmp++;
      if (iss_q.size() != 0 || rsp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: got %0d issues %0d responses pending, want 0", iss_q.size(), rsp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
